// File: rtl/regfile_2r2w_pipelined.sv
// General-purpose register file with two byte read ports, one pair read port,
// a byte write and an aligned word write; reads see this edge's writes.

module regfile_cell #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5,
  parameter int IDX    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                ww_en,
  input  logic [ADDR_W-2:0]   ww_addr,
  input  logic [2*WIDTH-1:0]  ww_data,
  output logic [WIDTH-1:0]    nxt
);
  localparam logic [ADDR_W-1:0] ID = IDX[ADDR_W-1:0];

  logic [WIDTH-1:0] q;

  // Cells exist only below DEPTH and DEPTH is even, so an address match
  // already implies the write is in range. Byte write is applied last: it wins.
  always_comb begin
    nxt = q;
    if (ww_en && ww_addr == ID[ADDR_W-1:1])
      nxt = ID[0] ? ww_data[2*WIDTH-1:WIDTH] : ww_data[WIDTH-1:0];
    if (wr_en && wr_addr == ID)
      nxt = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end
endmodule

module regfile_2r2w_pipelined #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic [ADDR_W-2:0]   rp_addr,
  output logic [WIDTH-1:0]    rd_data_a,
  output logic [WIDTH-1:0]    rd_data_b,
  output logic [2*WIDTH-1:0]  rp_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                ww_en,
  input  logic [ADDR_W-2:0]   ww_addr,
  input  logic [2*WIDTH-1:0]  ww_data,
  output logic                wr_conflict
);
  localparam int                NSLOT   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];

  // Post-write view of every address slot; slots at or above DEPTH read as 0,
  // which gives out-of-range reads their zero result without extra muxing.
  logic [NSLOT-1:0][WIDTH-1:0] nxt;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < DEPTH) begin : g_reg
      regfile_cell #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .IDX    (i)
      ) u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ww_en   (ww_en),
        .ww_addr (ww_addr),
        .ww_data (ww_data),
        .nxt     (nxt[i])
      );
    end else begin : g_pad
      assign nxt[i] = '0;
    end
  end

  logic wr_ok, ww_ok, conflict;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign ww_ok    = ww_en && ({1'b0, ww_addr, 1'b1} < DEPTH_W);
  assign conflict = wr_ok && ww_ok && (wr_addr[ADDR_W-1:1] == ww_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a   <= '0;
      rd_data_b   <= '0;
      rp_data     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict;
      if (rd_en) begin
        rd_data_a <= nxt[rd_addr_a];
        rd_data_b <= nxt[rd_addr_b];
        rp_data   <= {nxt[{rp_addr, 1'b1}], nxt[{rp_addr, 1'b0}]};
      end
    end
  end
endmodule

// File: tb/tb_regfile_2r2w_pipelined.sv
// Scoreboard bench: two register files (32 and 24 deep) share stimulus; a
// monitor compares every post-edge output set against a plain array model.

module tb_regfile_2r2w_pipelined;
  localparam int W  = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
  logic [AW-2:0] rp_addr = '0, ww_addr = '0;
  logic          wr_en = 1'b0, ww_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic [2*W-1:0] ww_data = '0;

  logic [W-1:0]   a32, b32, a24, b24;
  logic [2*W-1:0] p32, p24;
  logic           c32, c24;

  always #5 clk = ~clk;

  regfile_2r2w_pipelined #(.WIDTH(W), .DEPTH(32), .ADDR_W(AW)) u32 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rp_addr(rp_addr), .rd_data_a(a32), .rd_data_b(b32),
    .rp_data(p32), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ww_en(ww_en), .ww_addr(ww_addr), .ww_data(ww_data), .wr_conflict(c32));

  regfile_2r2w_pipelined #(.WIDTH(W), .DEPTH(24), .ADDR_W(AW)) u24 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rp_addr(rp_addr), .rd_data_a(a24), .rd_data_b(b24),
    .rp_data(p24), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ww_en(ww_en), .ww_addr(ww_addr), .ww_data(ww_data), .wr_conflict(c24));

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           c;
  } exp_t;

  exp_t q32[$], q24[$];
  logic [W-1:0] mdl[2][32];
  exp_t held[2];
  int   dep[2] = '{32, 24};
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) mdl[k][r] = '0;
      held[k] = '0;
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, predict the post-edge
  // outputs of both instances, then advance to the next negedge.
  task automatic step(input bit re, input int ra, input int rb, input int rp,
                      input bit we, input int wa, input int wd,
                      input bit wwe, input int wwa, input int wwd);
    rd_en = re; rd_addr_a = AW'(ra); rd_addr_b = AW'(rb); rp_addr = (AW-1)'(rp);
    wr_en = we; wr_addr = AW'(wa); wr_data = W'(wd);
    ww_en = wwe; ww_addr = (AW-1)'(wwa); ww_data = (2*W)'(wwd);
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] nm[32];
      exp_t e;
      bit w_in, ww_in;
      nm = mdl[k];
      w_in  = we && wa < dep[k];
      ww_in = wwe && (2 * wwa + 1) < dep[k];
      if (ww_in) begin
        nm[2 * wwa]     = W'(wwd);
        nm[2 * wwa + 1] = W'(wwd >> W);
      end
      if (w_in) nm[wa] = W'(wd);
      e = held[k];
      if (re) begin
        e.a = (ra < dep[k]) ? nm[ra] : '0;
        e.b = (rb < dep[k]) ? nm[rb] : '0;
        e.p = ((2 * rp + 1) < dep[k]) ? {nm[2 * rp + 1], nm[2 * rp]} : '0;
      end
      e.c = w_in && ww_in && (wa / 2 == wwa);
      held[k] = e;
      mdl[k]  = nm;
      if (k == 0) q32.push_back(e);
      else        q24.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      #1;
      if (q32.size() == 0 || q24.size() == 0) begin
        chk("scoreboard_underflow", 32'(q32.size() + q24.size()), 32'd2);
      end else begin
        e = q32.pop_front();
        chk("d32_rd_a", 32'(a32), 32'(e.a));
        chk("d32_rd_b", 32'(b32), 32'(e.b));
        chk("d32_rp",   32'(p32), 32'(e.p));
        chk("d32_conf", 32'(c32), 32'(e.c));
        e = q24.pop_front();
        chk("d24_rd_a", 32'(a24), 32'(e.a));
        chk("d24_rd_b", 32'(b24), 32'(e.b));
        chk("d24_rp",   32'(p24), 32'(e.p));
        chk("d24_conf", 32'(c24), 32'(e.c));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a32"}, 32'(a32), 0); chk({tag, "_b32"}, 32'(b32), 0);
    chk({tag, "_p32"}, 32'(p32), 0); chk({tag, "_c32"}, 32'(c32), 0);
    chk({tag, "_a24"}, 32'(a24), 0); chk({tag, "_b24"}, 32'(b24), 0);
    chk({tag, "_p24"}, 32'(p24), 0); chk({tag, "_c24"}, 32'(c24), 0);
  endtask

  initial begin
    clear_model();
    #12;
    chk_all_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    idle();
    step(0, 0, 0, 0, 1, 3, 'h3C, 0, 0, 0);             // reg3 = 3C
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);                // read reg3
    step(1, 17, 17, 0, 1, 17, 'h99, 0, 0, 0);          // forwarded byte
    step(1, 0, 0, 13, 0, 0, 0, 1, 13, 'h1234);         // Z pair, forwarded
    step(1, 26, 27, 13, 0, 0, 0, 0, 0, 0);
    step(1, 28, 29, 14, 1, 29, 'h55, 1, 14, 'hBEEF);   // conflict, byte wins
    step(1, 28, 29, 14, 0, 0, 0, 0, 0, 0);             // conflict clears
    step(1, 3, 3, 1, 1, 2, 'h22, 1, 1, 'hAAAA);        // same-pair conflict, low byte
    step(0, 7, 9, 5, 1, 3, 'h11, 1, 5, 'h4321);        // hold while writing
    step(0, 8, 8, 6, 1, 10, 'h0A, 0, 0, 0);
    step(1, 30, 3, 15, 1, 30, 'h6E, 0, 0, 0);          // range: addr 30
    step(1, 30, 31, 15, 0, 0, 0, 1, 15, 'hC0DE);       // range: pair 15
    step(1, 23, 22, 11, 1, 23, 'h77, 1, 11, 'h1188);   // last valid slot of 24
    idle();

    // Async reset mid-write: preload reg5, then reset between edges.
    step(0, 0, 0, 0, 1, 5, 'hA5, 0, 0, 0);
    step(1, 5, 5, 2, 0, 0, 0, 0, 0, 0);
    rd_en = 1'b1; rd_addr_a = 5; wr_en = 1'b1; wr_addr = 5; wr_data = 'h77;
    ww_en = 1'b1; ww_addr = 2; ww_data = 'h5A5A;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_async");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step(1, 5, 4, 2, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      int wa, wwa;
      wa  = $urandom_range(0, 31);
      wwa = ($urandom_range(0, 3) == 0) ? wa / 2 : $urandom_range(0, 15);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 15), $urandom_range(0, 1) == 1, wa, $urandom_range(0, 255),
           $urandom_range(0, 1) == 1, wwa, $urandom_range(0, 65535));
    end
    idle();
    idle();

    chk("scoreboard_drained", 32'(q32.size() + q24.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
